// File: rtl/alm_pkg.sv
// Shared sizing helpers and constants for the ALM (Mitchell log-domain) arithmetic units.
package alm_pkg;

  localparam int DEF_BW = 16;
  localparam int DEF_F  = 8;

  // Divide-by-zero saturation pattern, sliced to the quotient width at use.
  localparam logic [127:0] DBZ_ONES = '1;

  function automatic int log2Width(input int bw);
    return $clog2(bw);
  endfunction

  function automatic int expWidth(input int bw);
    return $clog2(bw) + 1;
  endfunction

  function automatic int quotWidth(input int bw, input int f);
    return bw + f;
  endfunction

  // Wide enough for e + F - (BW-1) over the full signed exponent range.
  function automatic int shiftWidth(input int bw, input int f);
    return $clog2(2 * bw + f) + 1;
  endfunction

endpackage

// File: rtl/alm_antilog_shift.sv
// Antilog stage: scales a Q1.(BW-1) mantissa by a signed power of two into a BW.F fixed-point result.
module alm_antilog_shift
  import alm_pkg::*;
#(
  parameter int BW = DEF_BW,
  parameter int F  = DEF_F,
  parameter int SW = shiftWidth(BW, F)
) (
  input  logic [BW:0]        mant_i,
  input  logic signed [SW-1:0] shift_i,
  output logic [BW+F-1:0]    quot_o
);

  localparam int QW = BW + F;

  logic [QW-1:0] ext;
  logic [SW-1:0] mag;

  // Shifts of QW or more in either direction leave nothing; right shifts truncate.
  always_comb begin
    ext = QW'(mant_i);
    mag = shift_i[SW-1] ? (~shift_i + SW'(1)) : shift_i;
    if (mag >= SW'(QW)) begin
      ext = '0;
    end else if (shift_i[SW-1]) begin
      ext = ext >> mag;
    end else begin
      ext = ext << mag;
    end
    quot_o = ext;
  end

endmodule

// File: rtl/alm_div_pipe.sv
// Three-stage elastic Mitchell divider: log conversion, log subtraction, antilog with exception override.
module alm_div_pipe
  import alm_pkg::*;
#(
  parameter int BW      = DEF_BW,
  parameter int F       = DEF_F,
  parameter int LOG2_BW = log2Width(BW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   dividend,
  input  logic [BW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BW+F-1:0] quotient,
  output logic            div_by_zero
);

  localparam int EW = LOG2_BW + 1;
  localparam int QW = quotWidth(BW, F);
  localparam int SW = shiftWidth(BW, F);

  function automatic logic [LOG2_BW-1:0] leadOne(input logic [BW-1:0] v);
    logic [LOG2_BW-1:0] pos;
    pos = '0;
    for (int i = 0; i < BW; i++) begin
      if (v[i]) pos = LOG2_BW'(i);
    end
    return pos;
  endfunction

  function automatic logic [BW-2:0] logFrac(input logic [BW-1:0] v, input logic [LOG2_BW-1:0] k);
    logic [BW-1:0] aligned;
    aligned = v << (LOG2_BW'(BW - 1) - k);
    return aligned[BW-2:0];
  endfunction

  logic               adv;
  logic               s1Valid_q, s1Valid_d, s2Valid_q, s2Valid_d, s3Valid_q, s3Valid_d;
  logic [LOG2_BW-1:0] kA_q, kA_d, kB_q, kB_d;
  logic [BW-2:0]      xA_q, xA_d, xB_q, xB_d;
  logic               zA1_q, zA1_d, zB1_q, zB1_d, zA2_q, zA2_d, zB2_q, zB2_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [BW:0]        m_q, m_d;
  logic [QW-1:0]      quot_q, quot_d;
  logic               dbz_q, dbz_d;
  logic signed [EW-1:0] eDiff;
  logic               borrow;
  logic signed [SW-1:0] shiftAmt;
  logic [QW-1:0]      shifted;

  assign adv         = !s3Valid_q || out_ready;
  assign in_ready    = adv;
  assign out_valid   = s3Valid_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;

  assign eDiff    = EW'(kA_q) - EW'(kB_q);
  assign borrow   = xA_q < xB_q;
  assign shiftAmt = {{(SW - EW){e_q[EW-1]}}, e_q} + SW'(F) - SW'(BW - 1);

  alm_antilog_shift #(.BW(BW), .F(F), .SW(SW)) uAntilog (
    .mant_i (m_q),
    .shift_i(shiftAmt),
    .quot_o (shifted)
  );

  // Each stage loads only on advance, and only real transactions overwrite its payload.
  always_comb begin
    s1Valid_d = s1Valid_q;
    kA_d = kA_q;  kB_d = kB_q;  xA_d = xA_q;  xB_d = xB_q;
    zA1_d = zA1_q; zB1_d = zB1_q;
    s2Valid_d = s2Valid_q;
    e_d = e_q;  m_d = m_q;  zA2_d = zA2_q;  zB2_d = zB2_q;
    s3Valid_d = s3Valid_q;
    quot_d = quot_q;  dbz_d = dbz_q;
    if (adv) begin
      s1Valid_d = in_valid;
      s2Valid_d = s1Valid_q;
      s3Valid_d = s2Valid_q;
      if (in_valid) begin
        kA_d  = leadOne(dividend);
        kB_d  = leadOne(divisor);
        xA_d  = logFrac(dividend, leadOne(dividend));
        xB_d  = logFrac(divisor, leadOne(divisor));
        zA1_d = (dividend == '0);
        zB1_d = (divisor == '0);
      end
      if (s1Valid_q) begin
        e_d   = borrow ? (eDiff - EW'(1)) : eDiff;
        m_d   = borrow ? ({2'b10, xA_q} - {2'b00, xB_q}) : ({2'b01, xA_q} - {2'b00, xB_q});
        zA2_d = zA1_q;
        zB2_d = zB1_q;
      end
      if (s2Valid_q) begin
        dbz_d  = zB2_q;
        quot_d = zB2_q ? DBZ_ONES[QW-1:0] : (zA2_q ? '0 : shifted);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;  s2Valid_q <= 1'b0;  s3Valid_q <= 1'b0;
      kA_q <= '0;  kB_q <= '0;  xA_q <= '0;  xB_q <= '0;
      zA1_q <= 1'b0;  zB1_q <= 1'b0;  zA2_q <= 1'b0;  zB2_q <= 1'b0;
      e_q <= '0;  m_q <= '0;  quot_q <= '0;  dbz_q <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;  s2Valid_q <= s2Valid_d;  s3Valid_q <= s3Valid_d;
      kA_q <= kA_d;  kB_q <= kB_d;  xA_q <= xA_d;  xB_q <= xB_d;
      zA1_q <= zA1_d;  zB1_q <= zB1_d;  zA2_q <= zA2_d;  zB2_q <= zB2_d;
      e_q <= e_d;  m_q <= m_d;  quot_q <= quot_d;  dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_alm_div_pipe.sv
// Randomised and directed bench for alm_div_pipe against a floor-of-log Mitchell reference model.
module tb_alm_div_pipe;

  localparam int BW = 16;
  localparam int F  = 8;
  localparam int QW = BW + F;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] dividend;
  logic [BW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic          div_by_zero;

  int checks = 0;
  int failures = 0;
  int outCount = 0;
  logic [QW:0] expQ[$];

  always #5 clk = ~clk;

  alm_div_pipe #(.BW(BW), .F(F)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .div_by_zero(div_by_zero)
  );

  // Mitchell quotient from the real-valued log approximation:
  // L = log2~(A) - log2~(B); Q = 2^floor(L) * (1 + frac(L)), scaled by 2^F and truncated.
  function automatic logic [QW:0] refModel(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int ka, kb, sh;
    longint fa, fb, l, ip, fp, val;
    if (b == 0) return {1'b1, {QW{1'b1}}};
    if (a == 0) return '0;
    ka  = $clog2(int'(a) + 1) - 1;
    kb  = $clog2(int'(b) + 1) - 1;
    fa  = (longint'(a) - (longint'(1) << ka)) << (BW - 1 - ka);
    fb  = (longint'(b) - (longint'(1) << kb)) << (BW - 1 - kb);
    l   = longint'(ka - kb) * (longint'(1) << (BW - 1)) + fa - fb;
    ip  = l >>> (BW - 1);
    fp  = l - ip * (longint'(1) << (BW - 1));
    sh  = int'(ip) + F - (BW - 1);
    val = (longint'(1) << (BW - 1)) + fp;
    if (sh >= 0) val = val << sh;
    else         val = val >> (-sh);
    return {1'b0, val[QW-1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: retire an output transfer, record an input transfer, then move to just after the edge.
  task automatic tick(output bit acc);
    logic [QW:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      outCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput", 64'(out_valid), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("quotient", 64'(quotient), 64'(e[QW-1:0]));
        checkOutput("divByZero", 64'(div_by_zero), 64'(e[QW]));
      end
    end
    acc = in_valid && in_ready;
    if (acc) expQ.push_back(refModel(dividend, divisor));
    @(posedge clk);
    #1;
  endtask

  // Single isolated transaction with latency measured in edges from the accepting edge.
  task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b,
                               input logic [QW-1:0] expQuot, input logic expDbz);
    int lat;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("directedInReady", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'd3);
    checkOutput("directedQuotient", 64'(quotient), 64'(expQuot));
    checkOutput("directedDbz", 64'(div_by_zero), 64'(expDbz));
    @(posedge clk);
    #1;
    checkOutput("directedDrained", 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit acc;
    int accepted, base, cyc;
    logic [QW-1:0] held;
    logic [BW-1:0] bpA[5], bpB[5];
    logic [BW-1:0] dirA[8] = '{16'd64, 16'd12, 16'd7, 16'd4, 16'd1, 16'd5, 16'd0, 16'd0};
    logic [BW-1:0] dirB[8] = '{16'd8, 16'd4, 16'd3, 16'd12, 16'hFFFF, 16'd0, 16'd0, 16'd9};
    logic [QW-1:0] dirQ[8] = '{24'h000800, 24'h000300, 24'h000280, 24'h000060,
                               24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    logic          dirD[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("resetOutValid", 64'(out_valid), 64'd0);
    checkOutput("resetInReady", 64'(in_ready), 64'd1);
    checkOutput("resetQuotient", 64'(quotient), 64'd0);
    checkOutput("resetDbz", 64'(div_by_zero), 64'd0);

    for (int i = 0; i < 8; i++) applyStimulus(dirA[i], dirB[i], dirQ[i], dirD[i]);

    // Backpressure: five back-to-back inputs against a stalled sink.
    for (int i = 0; i < 5; i++) begin
      bpA[i] = 16'($urandom_range(1, 65535));
      bpB[i] = 16'($urandom_range(1, 255));
    end
    out_ready = 1'b0;
    accepted = 0;
    base = outCount;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      dividend = bpA[accepted];
      divisor  = bpB[accepted];
      tick(acc);
      if (acc) accepted++;
    end
    checkOutput("bpAccepted", 64'(accepted), 64'd3);
    checkOutput("bpInReady", 64'(in_ready), 64'd0);
    held = quotient;
    tick(acc);
    tick(acc);
    checkOutput("bpStable", 64'(quotient), 64'(held));
    out_ready = 1'b1;
    cyc = 0;
    while (accepted < 5 && cyc < 20) begin
      dividend = bpA[accepted];
      divisor  = bpB[accepted];
      tick(acc);
      if (acc) accepted++;
      cyc++;
    end
    in_valid = 1'b0;
    repeat (8) tick(acc);
    checkOutput("bpOutputs", 64'(outCount - base), 64'd5);
    checkOutput("bpQueueEmpty", 64'(expQ.size()), 64'd0);

    // Reset with three entries held in the pipeline.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom_range(1, 65535));
      divisor  = 16'($urandom_range(1, 65535));
      tick(acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    checkOutput("flushOutValid", 64'(out_valid), 64'd0);
    checkOutput("flushInReady", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    base = outCount;
    repeat (8) tick(acc);
    checkOutput("flushNoOutputs", 64'(outCount - base), 64'd0);

    // Random traffic on both handshakes.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      dividend  = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      divisor   = ($urandom_range(0, 31) == 0) ? 16'd0
                : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      tick(acc);
      if (acc) accepted++;
      cyc++;
    end
    checkOutput("randAccepted", 64'(accepted), 64'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick(acc);
    checkOutput("randQueueEmpty", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
